// File: rtl/lr5_pkg.sv
// lr5_pkg: shared matrix geometry, scan state encoding and clock-enable helpers
package lr5_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FRAME_W = ROWS * COLS;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  function automatic int ce_div(input int clk_ref, input int clk_ce);
    return clk_ref / clk_ce;
  endfunction

  function automatic int ce_width(input int clk_ref, input int clk_ce);
    return (ce_div(clk_ref, clk_ce) > 1) ? $clog2(ce_div(clk_ref, clk_ce)) : 1;
  endfunction

endpackage

// File: rtl/led_matrix_scan_ce_gen.sv
// ce_gen: free-running prescaler producing a one-cycle clock enable at CLK_CE
module ce_gen
  import lr5_pkg::*;
#(
  parameter int CLK_REF = 48_000_000,
  parameter int CLK_CE  = 1_000_000
) (
  input  logic clk,
  input  logic btnCpuReset,
  output logic ce
);

  localparam int DIV = ce_div(CLK_REF, CLK_CE);
  localparam int W   = ce_width(CLK_REF, CLK_CE);

  if (CLK_REF % CLK_CE != 0) begin : g_bad_ratio
    $error("ce_gen: CLK_REF must be an exact multiple of CLK_CE");
  end

  logic [W-1:0] count_q, count_d;

  assign ce = (count_q == W'(DIV - 1));

  // Count 0..DIV-1 and wrap on the enable cycle
  always_comb begin
    count_d = ce ? '0 : count_q + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) count_q <= '0;
    else              count_q <= count_d;
  end

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed 8x8 LED driver with double-buffered frames
module led_matrix_scan
  import lr5_pkg::*;
#(
  parameter int CLK_REF  = 48_000_000,
  parameter int CLK_CE   = 1_000_000,
  parameter int DWELL_CE = 4,
  parameter int BLANK_CE = 1
) (
  input  logic               clk,
  input  logic               btnCpuReset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic [ROWS-1:0]    STRING,
  output logic [COLS-1:0]    COLUMN,
  output logic               frame_start,
  output logic               frame_pending
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2((DWELL_CE > BLANK_CE ? DWELL_CE : BLANK_CE) + 1);

  if (BLANK_CE < 1) begin : g_bad_blank
    $error("led_matrix_scan: BLANK_CE must be at least 1");
  end

  logic               tick, last, boundary;
  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [FRAME_W-1:0] active_q, active_d, shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic [ROWS-1:0]    string_q, string_d;
  logic [COLS-1:0]    column_q, column_d;
  logic               frame_start_q, frame_start_d;

  ce_gen #(.CLK_REF(CLK_REF), .CLK_CE(CLK_CE)) u_ce (
    .clk        (clk),
    .btnCpuReset(btnCpuReset),
    .ce         (tick)
  );

  assign STRING        = string_q;
  assign COLUMN        = column_q;
  assign frame_start   = frame_start_q;
  assign frame_pending = pending_q;

  // Scan FSM, frame buffer swap and registered output decode
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tcnt_d   = tcnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    pending_d = pending_q;
    last = (state_q == BLANK) ? (tcnt_q == TW'(BLANK_CE - 1)) : (tcnt_q == TW'(DWELL_CE - 1));
    if (tick) begin
      if (last) begin
        tcnt_d  = '0;
        state_d = (state_q == BLANK) ? DRIVE : BLANK;
        row_d   = (state_q == DRIVE) ? row_q + 1'b1 : row_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    boundary = tick && last && (state_q == DRIVE) && (row_q == RW'(ROWS - 1));
    if (frame_valid) begin
      shadow_d  = frame_data;
      pending_d = !boundary;
      active_d  = boundary ? frame_data : active_q;
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    string_d      = (state_d == DRIVE) ? (ROWS'(1) << row_d) : '0;
    column_d      = (state_d == DRIVE) ? ~active_d[row_d*COLS +: COLS] : '1;
    frame_start_d = boundary;
  end

  // State, buffer and output registers
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q       <= BLANK;
      row_q         <= '0;
      tcnt_q        <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      string_q      <= '0;
      column_q      <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      tcnt_q        <= tcnt_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      string_q      <= string_d;
      column_q      <= column_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed self-checking bench for the LED matrix scanner
module tb_led_matrix_scan;

  logic        clk = 1'b0;
  logic        btn = 1'b0;
  logic [63:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic [7:0]  string_o, column_o;
  logic        frame_start, frame_pending;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int multi_hot = 0;

  always #5 clk = ~clk;

  led_matrix_scan dut (
    .clk          (clk),
    .btnCpuReset  (btn),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .STRING       (string_o),
    .COLUMN       (column_o),
    .frame_start  (frame_start),
    .frame_pending(frame_pending)
  );

  always @(negedge clk) if ($countones(string_o) > 1) multi_hot++;

  task automatic wait_edge(input int n);
    while (cur < n) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic do_reset();
    btn = 1'b0;
    frame_valid = 1'b0;
    frame_data = '0;
    #40;
    @(negedge clk);
    btn = 1'b1;
    cur = 0;
  endtask

  task automatic load_at(input int k, input logic [63:0] d);
    wait_edge(k - 1);
    frame_data = d;
    frame_valid = 1'b1;
    wait_edge(k);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    btn = 1'b0;
    frame_valid = 1'b0;
    #40;
    checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL reset_string got %h exp %h", string_o, 8'h00); end
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL reset_column got %h exp %h", column_o, 8'hFF); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fstart got %b exp 0", frame_start); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", frame_pending); end
    @(negedge clk);
    btn = 1'b1;
    cur = 0;
    wait_edge(47);
    checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL pre_tick_string got %h exp %h", string_o, 8'h00); end
    wait_edge(48);
    checks++; if (string_o !== 8'h01) begin errors++; $display("FAIL first_tick_string got %h exp %h", string_o, 8'h01); end
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL first_tick_column got %h exp %h", column_o, 8'hFF); end
  endtask

  task automatic test_load_swap();
    do_reset();
    load_at(10, 64'h0000_0000_0000_00A5);
    checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set got %b exp 1", frame_pending); end
    wait_edge(48);
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL swap_old_image got %h exp %h", column_o, 8'hFF); end
    wait_edge(1919);
    checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_held got %b exp 1", frame_pending); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL swap_fstart_early got %b exp 0", frame_start); end
    wait_edge(1920);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL swap_fstart got %b exp 1", frame_start); end
    checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL swap_blank_string got %h exp %h", string_o, 8'h00); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clr got %b exp 0", frame_pending); end
    wait_edge(1921);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL swap_fstart_width got %b exp 0", frame_start); end
    wait_edge(1968);
    checks++; if (string_o !== 8'h01) begin errors++; $display("FAIL swap_row0_string got %h exp %h", string_o, 8'h01); end
    checks++; if (column_o !== 8'h5A) begin errors++; $display("FAIL swap_row0_column got %h exp %h", column_o, 8'h5A); end
  endtask

  task automatic test_row_sweep();
    logic [7:0] one_hot;
    do_reset();
    load_at(10, 64'h8040_2010_0804_0201);
    for (int r = 0; r < 8; r++) begin
      one_hot = 8'h01 << r;
      wait_edge(1920 + 240 * r + 1);
      checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL sweep_blank_start row %0d got %h exp %h", r, string_o, 8'h00); end
      wait_edge(1967 + 240 * r);
      checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL sweep_blank_end row %0d got %h exp %h", r, string_o, 8'h00); end
      wait_edge(1968 + 240 * r);
      checks++; if (string_o !== one_hot) begin errors++; $display("FAIL sweep_string row %0d got %h exp %h", r, string_o, one_hot); end
      checks++; if (column_o !== ~one_hot) begin errors++; $display("FAIL sweep_column row %0d got %h exp %h", r, column_o, ~one_hot); end
      wait_edge(2159 + 240 * r);
      checks++; if (string_o !== one_hot) begin errors++; $display("FAIL sweep_dwell_end row %0d got %h exp %h", r, string_o, one_hot); end
      wait_edge(2160 + 240 * r);
      checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL sweep_off row %0d got %h exp %h", r, string_o, 8'h00); end
    end
    checks++; if (multi_hot !== 0) begin errors++; $display("FAIL sweep_multi_hot got %0d exp 0", multi_hot); end
  endtask

  task automatic test_last_write();
    int fs_cnt = 0;
    do_reset();
    for (int k = 1; k <= 3840; k++) begin
      if (k == 9)   begin frame_data = 64'hFF; frame_valid = 1'b1; end
      if (k == 10)  frame_valid = 1'b0;
      if (k == 499) begin frame_data = 64'h0F; frame_valid = 1'b1; end
      if (k == 500) frame_valid = 1'b0;
      wait_edge(k);
      if (frame_start) fs_cnt++;
      if (k == 1968) begin
        checks++; if (column_o !== 8'hF0) begin errors++; $display("FAIL last_write_column got %h exp %h", column_o, 8'hF0); end
      end
    end
    checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL last_write_fstarts got %0d exp 2", fs_cnt); end
  endtask

  task automatic test_collision();
    do_reset();
    load_at(1920, 64'h3C);
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL collide_pending got %b exp 0", frame_pending); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL collide_fstart got %b exp 1", frame_start); end
    wait_edge(1968);
    checks++; if (column_o !== 8'hC3) begin errors++; $display("FAIL collide_column got %h exp %h", column_o, 8'hC3); end
    wait_edge(3888);
    checks++; if (column_o !== 8'hC3) begin errors++; $display("FAIL collide_next_frame got %h exp %h", column_o, 8'hC3); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_at(10, 64'hFFFF_FFFF_FFFF_FFFF);
    load_at(3000, 64'h0000_0000_0000_0081);
    wait_edge(3200);
    checks++; if (string_o !== 8'h20) begin errors++; $display("FAIL midrst_row5_string got %h exp %h", string_o, 8'h20); end
    checks++; if (column_o !== 8'h00) begin errors++; $display("FAIL midrst_row5_column got %h exp %h", column_o, 8'h00); end
    btn = 1'b0;
    #2;
    checks++; if (string_o !== 8'h00) begin errors++; $display("FAIL midrst_string got %h exp %h", string_o, 8'h00); end
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL midrst_column got %h exp %h", column_o, 8'hFF); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL midrst_pending got %b exp 0", frame_pending); end
    #40;
    @(negedge clk);
    btn = 1'b1;
    cur = 0;
    wait_edge(48);
    checks++; if (string_o !== 8'h01) begin errors++; $display("FAIL midrst_restart_string got %h exp %h", string_o, 8'h01); end
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL midrst_restart_column got %h exp %h", column_o, 8'hFF); end
    wait_edge(1968);
    checks++; if (column_o !== 8'hFF) begin errors++; $display("FAIL midrst_discard got %h exp %h", column_o, 8'hFF); end
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_row_sweep();
    test_last_write();
    test_collision();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Downstream display stage of the LR5 top level. It consumes a 64-bit frame (8 rows x 8 columns) produced by the shift/LED logic.
- It drives the 8x8 matrix row lines (STRING) and column lines (COLUMN) by time-multiplexing one row at a time, paced by a 1 MHz clock enable derived from the 48 MHz system clock.
- Frames are double-buffered, so a new frame is applied only at a frame boundary and a partially scanned frame never mixes two images.

Parameters:
- CLK_REF, 48_000_000, system clock frequency in Hz.
- CLK_CE, 1_000_000, scan tick frequency in Hz. CLK_REF must be an exact multiple of CLK_CE; elaboration fails otherwise.
- DWELL_CE, 4, number of ticks each row is driven.
- BLANK_CE, 1, number of ticks of all-off blanking before each row (anti-ghosting). Must be >= 1.

Ports:
- clk  in  1  system clock, 48 MHz.
- btnCpuReset  in  1  asynchronous, active-low reset.
- frame_data  in  64  new frame. Bit r*8+c is row r, column c; 1 = LED on.
- frame_valid  in  1  one-cycle load strobe for frame_data.
- STRING  out  8  row select, one-hot, active-high.
- COLUMN  out  8  column drive, active-low (0 = LED on).
- frame_start  out  1  one-cycle pulse when row 0 blanking begins.
- frame_pending  out  1  a loaded frame is waiting for the next boundary.

Behaviour:
- Reset (async assert, sync release): clears prescaler, row index, state, active buffer, shadow buffer and pending.
  - Outputs at reset: STRING=8'h00, COLUMN=8'hFF, frame_start=0, frame_pending=0, state=BLANK.
- Prescaler: counts 0..CLK_REF/CLK_CE-1 (0..47 by default). Internal tick is high for one clk when count = max, then count wraps to 0.
  - First tick occurs 48 clks after reset release.
- Tick counter: counts ticks within the current state and resets on every state change.
- FSM states BLANK and DRIVE. All transitions happen only on clk edges where tick=1.
  - BLANK -> DRIVE on the BLANK_CE-th tick; row unchanged.
  - DRIVE -> BLANK on the DWELL_CE-th tick; row increments, wrapping 7 -> 0.
- All outputs are registered and reflect the new state in the cycle after the transition edge.
  - BLANK: STRING=8'h00, COLUMN=8'hFF.
  - DRIVE row r: STRING=(1<<r), COLUMN[c]=~active[r*8+c].
- Timing with defaults: row period = 5 ticks = 240 clks; frame period = 40 ticks = 1920 clks.
- Frame boundary is the DRIVE(row 7) -> BLANK(row 0) transition:
  - frame_start pulses for exactly one clk, asserted together with the row-0 BLANK outputs.
  - If pending=1: active <= shadow, pending <= 0.
- frame_valid, not at a boundary: shadow <= frame_data, pending <= 1.
  - A repeated frame_valid before the boundary overwrites shadow; the last write wins and only one swap occurs.
- frame_valid on the boundary edge: active <= frame_data directly (the new data bypasses the shadow); shadow <= frame_data; pending <= 0.
- frame_valid does not alter scan timing.
- frame_pending is the pending register.
- Reset mid-scan: outputs return to reset values immediately (async). Any pending frame is discarded.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package lr5_pkg holds:
  - ROWS=8, COLS=8, FRAME_W=64.
  - State encoding: BLANK=1'b0, DRIVE=1'b1.
  - Function ce_div(CLK_REF, CLK_CE) with prescaler width computed via $clog2.
- One sub-module, ce_gen: the prescaler. Parameters CLK_REF, CLK_CE; ports clk, btnCpuReset, ce.
  - It is reused elsewhere in LR5 for any 1 MHz pacing.
- FSM, buffers and output decode stay in led_matrix_scan.

Test Plan:
- Reset: hold btnCpuReset=0 for 40 ns, then release -> STRING=8'h00, COLUMN=8'hFF, frame_start=0. First tick occurs at clk 48 after release; STRING=8'h01 after the first tick, with COLUMN=8'hFF since active is all zeros.
- Load and swap: pulse frame_valid with 64'h0000_0000_0000_00A5 at clk 10 -> frame_pending=1 until the frame boundary at clk 1920.
  - frame_start pulses once at clk 1920.
  - After 1 blanking tick, STRING=8'h01 and COLUMN=8'h5A.
  - frame_pending=0 after the boundary.
- Row sweep: load 64'h8040_2010_0804_0201 (diagonal) -> during DRIVE of row r, STRING=(1<<r) and COLUMN=~(1<<r).
  - Every row is preceded by 48 clks of STRING=0.
  - STRING is never multi-hot.
- Last write wins: two frame_valid pulses (64'hFF, then 64'h0F) before the boundary -> row 0 shows COLUMN=8'hF0; exactly one frame_start per frame.
- Boundary collision: frame_valid with 64'h3C on the exact boundary edge -> row 0 of that same frame shows COLUMN=8'hC3; frame_pending stays 0.
- Mid-scan reset: assert btnCpuReset=0 during DRIVE of row 5 -> STRING=0 and COLUMN=FF within the same cycle. After release the scan restarts at row 0 with a blank (all-zero) image.
